// File: rtl/dmem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// dmem_bridge_pkg
// Shared definitions for the data-memory bridge: FSM state encodings, default
// parameter values and small address helpers.
// Optional feature macro used by the bridge: DMEM_BRIDGE_POSTED_WRITE_EN.
// -----------------------------------------------------------------------------
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          TIMEOUT_DEFAULT  = 16;
    // Timeout counter width; TIMEOUT_CYCLES is limited to 1..255.
    localparam int          TMR_W            = 8;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Byte address -> word-aligned bus address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// -----------------------------------------------------------------------------
// dmem_bridge interfaces
//   dmem_core_if : single-cycle core data-memory port.
//       master = CPU core (drives core_ren/core_wen/core_addr/core_wdata)
//       slave  = bridge   (drives core_rdata/core_stall)
//   dmem_bus_if  : multi-cycle request/acknowledge data bus.
//       master = bridge   (drives bus_req/bus_we/bus_addr/bus_wdata)
//       slave  = memory   (drives bus_rdata/bus_ack)
// -----------------------------------------------------------------------------
interface dmem_core_if;
    logic        core_ren;
    logic        core_wen;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;

    modport master (
        output core_ren, core_wen, core_addr, core_wdata,
        input  core_rdata, core_stall
    );

    modport slave (
        input  core_ren, core_wen, core_addr, core_wdata,
        output core_rdata, core_stall
    );
endinterface

interface dmem_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/dmem_bridge_timer.sv
// -----------------------------------------------------------------------------
// dmem_bridge_timer
// Loadable down-counter used as the bus timeout. Load with N-1 when a bus
// request is launched; with en_i asserted it counts down once per cycle and
// expired_o is high while the count is zero (i.e. in the Nth enabled cycle).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   load_i       : load load_val_i (lower priority than clr_i)
//   load_val_i   : reload value
//   en_i         : count enable
//   clr_i        : synchronous clear to zero
//   expired_o    : count is zero
// -----------------------------------------------------------------------------
module dmem_bridge_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
// Converts each single-cycle core data-memory access into one request/ack bus
// transaction, stalling the pipeline until it completes. A bus timeout and a
// sticky error flag keep a hung or absent slave from deadlocking the core.
//
// Parameters:
//   TIMEOUT_CYCLES : REQ cycles without bus_ack before abort (1..255)
//   ERR_DATA       : read data returned on a timed-out read
// Ports:
//   clk      : clock
//   rst      : asynchronous active-low reset
//   core     : dmem_core_if.slave (ren/wen/addr/wdata in, rdata/stall out)
//   bus      : dmem_bus_if.master (req/we/addr/wdata out, rdata/ack in)
//   err_flag : sticky error (timeout or misaligned access)
//   err_clr  : synchronous clear for err_flag (a same-cycle set wins)
//
// Optional feature: define DMEM_BRIDGE_POSTED_WRITE_EN to post writes. A write
// then does not stall in IDLE and its transaction returns from REQ straight to
// IDLE; any core request arriving while the FSM is busy stalls until IDLE.
// -----------------------------------------------------------------------------
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    dmem_core_if.slave  core,
    dmem_bus_if.master  bus,
    output logic        err_flag,
    input  logic        err_clr
);

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;

    logic        bus_req_q,    bus_req_d;
    logic        bus_we_q,     bus_we_d;
    logic [31:0] bus_addr_q,   bus_addr_d;
    logic [31:0] bus_wdata_q,  bus_wdata_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic        err_q,        err_d;

    logic        req_any;
    logic        launch;
    logic        ack_hit;
    logic        timeout_hit;
    logic        tmr_expired;
    logic        core_stall;

    assign req_any     = core.core_ren | core.core_wen;
    assign launch      = (state_q == ST_IDLE) & req_any;
    assign ack_hit     = (state_q == ST_REQ) & bus.bus_ack;
    // An ack in the expiry cycle takes precedence: normal completion.
    assign timeout_hit = (state_q == ST_REQ) & ~bus.bus_ack & tmr_expired;

    dmem_bridge_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (launch),
        .load_val_i (TMR_LOAD),
        .en_i       (state_q == ST_REQ),
        .clr_i      (ack_hit | timeout_hit),
        .expired_o  (tmr_expired)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_hit || timeout_hit) begin
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
                    // Posted writes were already consumed by the core.
                    state_d = bus_we_q ? ST_IDLE : ST_DONE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        core_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
                // Simultaneous ren/wen counts as a write, so it is posted too.
                core_stall = core.core_ren & ~core.core_wen;
`else
                core_stall = req_any;
`endif
            end
            ST_REQ: begin
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
                // Draining a posted write only blocks a new access.
                core_stall = req_any;
`else
                core_stall = 1'b1;
`endif
            end
            ST_DONE: core_stall = 1'b0;
            default: core_stall = 1'b0;
        endcase
    end

    // Bus fields, read-data return and error flag
    always_comb begin
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        core_rdata_d = core_rdata_q;

        if (launch) begin
            bus_req_d   = 1'b1;
            bus_we_d    = core.core_wen;
            bus_addr_d  = word_align(core.core_addr);
            bus_wdata_d = core.core_wdata;
        end

        if (ack_hit) begin
            bus_req_d = 1'b0;
            if (!bus_we_q) begin
                core_rdata_d = bus.bus_rdata;
            end
        end else if (timeout_hit) begin
            bus_req_d = 1'b0;
            if (!bus_we_q) begin
                core_rdata_d = ERR_DATA;
            end
        end

        if ((launch && is_misaligned(core.core_addr)) || timeout_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            core_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            core_rdata_q <= core_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.bus_req     = bus_req_q;
    assign bus.bus_we      = bus_we_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wdata   = bus_wdata_q;
    assign core.core_rdata = core_rdata_q;
    assign core.core_stall = core_stall;
    assign err_flag        = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
// Self-checking bench for dmem_bridge (TIMEOUT_CYCLES = 4). A transaction-level
// reference model predicts stall count, bus request length, bus fields,
// returned read data and the sticky error flag for each core access.
// Honours DMEM_BRIDGE_POSTED_WRITE_EN for the posted-write expectations.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

    localparam int          T        = 4;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic clk;
    logic rst;
    logic err_flag;
    logic err_clr;

    dmem_core_if core_if ();
    dmem_bus_if  bus_if ();

    dmem_bridge #(
        .TIMEOUT_CYCLES (T),
        .ERR_DATA       (ERR_WORD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .core     (core_if),
        .bus      (bus_if),
        .err_flag (err_flag),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference-model state
    logic [31:0] m_rdata = '0;
    bit          m_err   = 1'b0;

    // Bus slave controls
    int          ack_dly    = 0;
    int          slv_cnt    = 0;
    logic [31:0] rdata_val  = '0;
    bit          noise_en   = 1'b0;
    bit          inject_ack = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Slave: acks in the ack_dly-th cycle of a request; 0 or > T never acks.
    // While no request is pending it may emit stray acks that must be ignored.
    always @(negedge clk) begin
        if (bus_if.bus_req) begin
            slv_cnt = slv_cnt + 1;
            bus_if.bus_ack = (slv_cnt == ack_dly);
        end else begin
            slv_cnt = 0;
            bus_if.bus_ack = inject_ack | (noise_en && ($urandom_range(0, 3) == 0));
        end
        bus_if.bus_rdata = bus_if.bus_ack ? rdata_val : $urandom;
    end

    // One core access, entered right after a negedge with the bridge idle.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int dly,
                          input logic [31:0] rv, input bit clr_first);
        bit   acked;
        int   exp_req;
        int   exp_stall;
        int   stalls;
        int   req_cycles;
        bit   consumed;
        bit   drained;

        acked     = (dly >= 1) && (dly <= T);
        exp_req   = acked ? dly : T;
        exp_stall = (POSTED && wr) ? 0 : 1 + exp_req;
        if (!wr) m_rdata = acked ? rv : ERR_WORD;
        m_err = (clr_first ? 1'b0 : m_err) | (addr[1:0] != 2'b00) | !acked;

        ack_dly   = dly;
        rdata_val = rv;
        core_if.core_ren   = rd;
        core_if.core_wen   = wr;
        core_if.core_addr  = addr;
        core_if.core_wdata = wdata;
        err_clr = clr_first;

        stalls = 0; req_cycles = 0; consumed = 0; drained = 0;
        #2;
        for (int c = 0; c < 60; c++) begin
            if (bus_if.bus_req) begin
                req_cycles++;
                chk("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
                chk("bus_we", 32'(bus_if.bus_we), 32'(wr));
                if (wr) chk("bus_wdata", bus_if.bus_wdata, wdata);
            end
            if (!consumed) begin
                if (core_if.core_stall) begin
                    stalls++;
                end else begin
                    consumed = 1;
                    chk("stall_cycles", stalls, exp_stall);
                    chk("core_rdata", core_if.core_rdata, m_rdata);
                end
            end
            if (consumed && !bus_if.bus_req && c > 0) begin
                drained = 1;
                break;
            end
            @(negedge clk);
            err_clr = 1'b0;
            if (consumed) begin
                core_if.core_ren = 1'b0;
                core_if.core_wen = 1'b0;
            end
            #2;
        end
        chk("drained", 32'(drained), 32'd1);
        chk("req_cycles", req_cycles, exp_req);
        chk("err_flag", 32'(err_flag), 32'(m_err));
        @(negedge clk);
        core_if.core_ren = 1'b0;
        core_if.core_wen = 1'b0;
        err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        err_clr = 1'b0;
        core_if.core_ren   = 1'b0;
        core_if.core_wen   = 1'b0;
        core_if.core_addr  = '0;
        core_if.core_wdata = '0;
        bus_if.bus_ack     = 1'b0;
        bus_if.bus_rdata   = '0;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst_core_rdata", core_if.core_rdata, 32'd0);
        chk("rst_err", 32'(err_flag), 32'd0);
        chk("rst_stall", 32'(core_if.core_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Read, ack on first REQ cycle
        access(1, 0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 0);
        // Write, ack after 3 cycles
        access(0, 1, 32'h0000_0100, 32'hA5A5_A5A5, 3, 32'h0BAD_0BAD, 0);
        // Read with no ack: timeout
        access(1, 0, 32'h0000_0080, 32'h0, 0, 32'h7777_7777, 0);
        // err_flag stays until cleared
        @(negedge clk);
        #2 chk("err_sticky", 32'(err_flag), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        #2 chk("err_cleared", 32'(err_flag), 32'd0);
        // Misaligned read, normal data
        access(1, 0, 32'h0000_0103, 32'h0, 2, 32'hCAFE_F00D, 0);
        // Misaligned with err_clr in the same cycle: set wins
        access(1, 0, 32'h0000_0202, 32'h0, 1, 32'h1357_9BDF, 1);
        // Ack in the timeout cycle: normal completion, no new error
        access(1, 0, 32'h0000_0300, 32'h0, T, 32'h2468_ACE0, 1);
        // Both ren and wen: treated as write
        access(1, 1, 32'h0000_0400, 32'h5555_AAAA, 2, 32'h0, 0);

        // Reset in the middle of REQ
        noise_en = 1'b0;
        ack_dly  = 0;
        core_if.core_ren  = 1'b1;
        core_if.core_addr = 32'h0000_0500;
        @(negedge clk);
        @(negedge clk);
        #2 chk("mid_req_active", 32'(bus_if.bus_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("arst_bus_addr", bus_if.bus_addr, 32'd0);
        chk("arst_core_rdata", core_if.core_rdata, 32'd0);
        chk("arst_err", 32'(err_flag), 32'd0);
        chk("arst_stall_req", 32'(core_if.core_stall), 32'd1);
        core_if.core_ren = 1'b0;
        #1 chk("arst_stall_noreq", 32'(core_if.core_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        m_rdata = '0;
        m_err   = 1'b0;
        #2 inject_ack = 1'b1;
        @(negedge clk);
        #2 inject_ack = 1'b0;
        @(negedge clk);
        #2;
        chk("late_ack_req", 32'(bus_if.bus_req), 32'd0);
        chk("late_ack_rdata", core_if.core_rdata, 32'd0);
        chk("late_ack_stall", 32'(core_if.core_stall), 32'd0);
        @(negedge clk);

`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
        // Posted write followed next cycle by a read of the same word
        begin
            int stalls;
            ack_dly   = 3;
            rdata_val = 32'h600D_DA7A;
            core_if.core_wen   = 1'b1;
            core_if.core_addr  = 32'h0000_0200;
            core_if.core_wdata = 32'h1111_2222;
            #2 chk("pw_stall", 32'(core_if.core_stall), 32'd0);
            @(negedge clk);
            core_if.core_wen = 1'b0;
            core_if.core_ren = 1'b1;
            #2;
            chk("pw_bus_we", 32'(bus_if.bus_we), 32'd1);
            chk("pw_bus_addr", bus_if.bus_addr, 32'h0000_0200);
            stalls = 0;
            for (int c = 0; c < 40 && core_if.core_stall; c++) begin
                stalls++;
                if (bus_if.bus_req && !bus_if.bus_we)
                    chk("raw_bus_addr", bus_if.bus_addr, 32'h0000_0200);
                @(negedge clk);
                #2;
            end
            // 3 write REQ cycles + IDLE launch + 3 read REQ cycles
            chk("raw_stalls", stalls, 7);
            chk("raw_rdata", core_if.core_rdata, 32'h600D_DA7A);
            m_rdata = 32'h600D_DA7A;
            @(negedge clk);
            core_if.core_ren = 1'b0;
            @(negedge clk);
        end
`endif

        // Randomized accesses
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 2);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            access(sel != 1, sel != 0, a, $urandom, $urandom_range(0, T + 1),
                   $urandom, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
